// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave on the MMIO slot bus; oversamples SCLK/MOSI/SS_N in the clk domain,
// shifts bytes MSB-first in all four CPOL/CPHA modes, with rx/tx slot registers and overrun detection.
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   cs, read, write, addr   slot select/strobes; only addr[1:0] decoded (01 tx_hold, 11 config, 00 read-clear)
//   wr_data, rd_data        write data; status word {16'b0, ie_tx, ie_rx, cpha, cpol, busy, ovr, tx_empty, rx_valid, rx_data}
//   spi_sclk, spi_mosi      external master clock and data, asynchronous to clk
//   spi_ss_n                active-low slave select
//   spi_miso                slave data out, 0 while deselected
//   irq                     level interrupt, present only when SPI_SLV_IRQ_EN is defined
module spi_slave_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        spi_ss_n
`ifdef SPI_SLV_IRQ_EN
    ,
    output logic        irq
`endif
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic sclk_s, mosi_s, ss_n_s, sclk_d;
    logic cpol, cpha, ie_rx, ie_tx;
    logic [7:0] tx_hold, tx_sh, rx_sh, rx_data;
    logic [2:0] bit_cnt;
    logic tx_empty, rx_valid, ovr, busy;
    logic m, m_d, start, stop, sample, shift, done;
    logic tx_wr, cfg_wr, rd_clr, load;
    logic unused;

    assign unused = ^{wr_data[31:8], wr_data[3:2], addr[4:2]};
    assign tx_wr  = cs & write & (addr[1:0] == 2'b01);
    assign cfg_wr = cs & write & (addr[1:0] == 2'b11);
    assign rd_clr = cs & read & (addr[1:0] == 2'b00);

    // ss_n synchronizer resets to deselected so reset release never fakes a select edge
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sclk_d    <= sclk_s;
        end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_n_s = ss_sync[SYNC_STAGES-1];
    // folding cpol/cpha into the clock makes rising m the sample edge in every mode
    assign m      = sclk_s ^ cpol ^ cpha;
    assign m_d    = sclk_d ^ cpol ^ cpha;
    assign busy   = (state == ACTIVE);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        sample     = 1'b0;
        shift      = 1'b0;
        if (state == IDLE) begin
            if (!ss_n_s) begin
                state_next = ACTIVE;
                start      = 1'b1;
            end
        end else if (ss_n_s) begin
            state_next = IDLE;
            stop       = 1'b1;
        end else begin
            sample = m & ~m_d;
            // the leading shift edge of a byte is suppressed so CPHA=1 keeps the MSB on the wire
            shift  = ~m & m_d & (bit_cnt != 3'd0);
        end
    end

    assign done = sample & (bit_cnt == 3'd7);
    assign load = start | done;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state    <= IDLE;
            tx_hold  <= 8'h00;
            tx_sh    <= 8'hFF;
            rx_sh    <= 8'h00;
            rx_data  <= 8'h00;
            bit_cnt  <= 3'd0;
            tx_empty <= 1'b1;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
            cpol     <= 1'b0;
            cpha     <= 1'b0;
        end else begin
            state <= state_next;
            if (tx_wr)
                tx_hold <= wr_data[7:0];
            if (cfg_wr) begin
                cpol <= wr_data[0];
                cpha <= wr_data[1];
            end
            // a load sees the pre-write tx_hold; a same-cycle CPU write still leaves tx_empty clear
            if (load)
                tx_sh <= tx_empty ? 8'hFF : tx_hold;
            else if (shift)
                tx_sh <= {tx_sh[6:0], 1'b0};
            tx_empty <= tx_wr ? 1'b0 : load ? 1'b1 : tx_empty;
            if (start || stop)
                bit_cnt <= 3'd0;
            else if (sample)
                bit_cnt <= bit_cnt + 3'd1;
            if (sample)
                rx_sh <= {rx_sh[6:0], mosi_s};
            if (done)
                rx_data <= {rx_sh[6:0], mosi_s};
            // completion wins over a same-cycle read-clear and then does not flag overrun
            rx_valid <= done ? 1'b1 : rd_clr ? 1'b0 : rx_valid;
            ovr      <= (done && rx_valid && !rd_clr) ? 1'b1 : rd_clr ? 1'b0 : ovr;
        end

`ifdef SPI_SLV_IRQ_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ie_rx <= 1'b0;
            ie_tx <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (cfg_wr) begin
                ie_rx <= wr_data[2];
                ie_tx <= wr_data[3];
            end
            irq <= (rx_valid & ie_rx) | (tx_empty & ie_tx & busy) | ovr;
        end
`else
    assign ie_rx = 1'b0;
    assign ie_tx = 1'b0;
`endif

    assign rd_data  = {16'b0, ie_tx, ie_rx, cpha, cpol, busy, ovr, tx_empty, rx_valid, rx_data};
    assign spi_miso = busy & tx_sh[7];
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: scoreboard bench; a behavioural SPI master drives the core and a monitor checks received bytes.
module tb_spi_slave_core;
    localparam int H = 4;
    logic clk = 1'b0, reset = 1'b1, cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0] addr = '0;
    logic [31:0] wr_data = '0, rd_data;
    logic sclk = 1'b0, mosi = 1'b0, miso, ss_n = 1'b1;
`ifdef SPI_SLV_IRQ_EN
    logic irq;
`endif
    int n_chk = 0, n_fail = 0;
    logic m_cpol = 1'b0, m_cpha = 1'b0;
    logic [7:0] exp_miso_q[$], exp_rx_q[$], got_q[$];
    logic prev_rv = 1'b0;

    spi_slave_core dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .spi_sclk(sclk), .spi_mosi(mosi),
        .spi_miso(miso), .spi_ss_n(ss_n)
`ifdef SPI_SLV_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // monitor: pops expectations whenever the core presents a new byte or the master finishes one
    always @(negedge clk) begin
        if (!reset && rd_data[8] && !prev_rv) begin
            if (exp_rx_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rx_unexpected: got %h expected none", rd_data[7:0]);
            end else
                chk("rx_data", {24'b0, rd_data[7:0]}, {24'b0, exp_rx_q.pop_front()});
        end
        prev_rv = rd_data[8];
        if (got_q.size() != 0) begin
            if (exp_miso_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL miso_unexpected: got %h expected none", got_q.pop_front());
            end else
                chk("miso_byte", {24'b0, got_q.pop_front()}, {24'b0, exp_miso_q.pop_front()});
        end
    end

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic read_clr();
        @(negedge clk);
        cs = 1'b1; read = 1'b1; addr = 5'd0;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic set_mode(input int mode, input logic [1:0] ie);
        m_cpol = mode[1];
        m_cpha = mode[0];
        bus_write(5'd3, {28'b0, ie, m_cpha, m_cpol});
        sclk = m_cpol;
        repeat (H) @(negedge clk);
    endtask

    task automatic ss_low();
        @(negedge clk);
        ss_n = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (H) @(negedge clk);
        ss_n = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    // textbook SPI master: CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge
    task automatic xfer(input logic [7:0] mo, input int nb, input bit push);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            if (!m_cpha) begin
                mosi = mo[i];
                repeat (H) @(negedge clk);
                r = {r[6:0], miso};
                sclk = ~m_cpol;
                repeat (H) @(negedge clk);
                sclk = m_cpol;
            end else begin
                sclk = ~m_cpol;
                mosi = mo[i];
                repeat (H) @(negedge clk);
                r = {r[6:0], miso};
                sclk = m_cpol;
                repeat (H) @(negedge clk);
            end
        end
        if (push) got_q.push_back(r);
    endtask

    initial begin
        logic [7:0] tx, mo;
        int mode;
        bit has;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rd_data", rd_data, 32'h200);
        chk("reset_miso", {31'b0, miso}, 32'h0);
`ifdef SPI_SLV_IRQ_EN
        chk("reset_irq", {31'b0, irq}, 32'h0);
        bus_write(5'd3, 32'hC);
        chk("ie_bits", {28'b0, rd_data[15:12]}, 32'hC);
`else
        bus_write(5'd3, 32'hC);
        chk("ie_bits", {28'b0, rd_data[15:12]}, 32'h0);
`endif
        set_mode(0, 2'b00);

        bus_write(5'd1, 32'hA5);
        chk("tx_empty_after_write", {31'b0, rd_data[9]}, 32'h0);
        exp_miso_q.push_back(8'hA5);
        exp_rx_q.push_back(8'h3C);
        ss_low();
        xfer(8'h3C, 8, 1);
        ss_high();
        chk("mode0_status", {23'b0, rd_data[8:0]}, 32'h13C);
        chk("mode0_tx_empty", {31'b0, rd_data[9]}, 32'h1);
        read_clr();

        for (int md = 1; md < 4; md++) begin
            set_mode(md, 2'b00);
            bus_write(5'd1, 32'h81);
            exp_miso_q.push_back(8'h81);
            exp_rx_q.push_back(8'h7E);
            ss_low();
            xfer(8'h7E, 8, 1);
            ss_high();
            chk($sformatf("mode%0d_rx", md), {24'b0, rd_data[7:0]}, 32'h7E);
            read_clr();
        end

        set_mode(0, 2'b00);
        bus_write(5'd1, 32'h11);
        exp_miso_q.push_back(8'h11);
        exp_miso_q.push_back(8'h22);
        exp_rx_q.push_back(8'h55);
        ss_low();
        fork
            xfer(8'h55, 8, 1);
            begin
                repeat (10) @(negedge clk);
                bus_write(5'd1, 32'h22);
            end
        join
        xfer(8'h66, 8, 1);
        ss_high();
        chk("b2b_rx_data", {24'b0, rd_data[7:0]}, 32'h66);
        chk("b2b_rx_valid", {31'b0, rd_data[8]}, 32'h1);
        chk("b2b_ovr", {31'b0, rd_data[10]}, 32'h1);
        read_clr();
        chk("clr_rx_valid", {31'b0, rd_data[8]}, 32'h0);
        chk("clr_ovr", {31'b0, rd_data[10]}, 32'h0);

        ss_low();
        xfer(8'hF0, 5, 0);
        ss_high();
        chk("partial_rx_valid", {31'b0, rd_data[8]}, 32'h0);
        chk("deselected_miso", {31'b0, miso}, 32'h0);
        bus_write(5'd1, 32'hC3);
        exp_miso_q.push_back(8'hC3);
        exp_rx_q.push_back(8'h96);
        ss_low();
        xfer(8'h96, 8, 1);
        ss_high();
        chk("after_partial_rx", {24'b0, rd_data[7:0]}, 32'h96);
        read_clr();

        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'h0F);
        ss_low();
        xfer(8'h0F, 8, 1);
        ss_high();
        read_clr();

        bus_write(5'd1, 32'h77);
        ss_low();
        xfer(8'hAA, 3, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("in_reset_miso", {31'b0, miso}, 32'h0);
        ss_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_reset_rd_data", rd_data, 32'h200);
        chk("mid_reset_miso", {31'b0, miso}, 32'h0);

        set_mode(0, 2'b00);
        exp_miso_q.push_back(8'hFF);
        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'hA1);
        ss_low();
        xfer(8'hA1, 8, 1);
        fork
            xfer(8'hB2, 8, 1);
            begin
                repeat (8) @(posedge sclk);
                @(negedge clk);
                read_clr();
            end
        join
        ss_high();
        chk("coinc_rx_valid", {31'b0, rd_data[8]}, 32'h1);
        chk("coinc_ovr", {31'b0, rd_data[10]}, 32'h0);
        chk("coinc_rx_data", {24'b0, rd_data[7:0]}, 32'hB2);
        read_clr();

`ifdef SPI_SLV_IRQ_EN
        set_mode(0, 2'b01);
        exp_miso_q.push_back(8'hFF);
        exp_rx_q.push_back(8'h3A);
        ss_low();
        xfer(8'h3A, 8, 1);
        ss_high();
        chk("irq_high", {31'b0, irq}, 32'h1);
        read_clr();
        repeat (2) @(negedge clk);
        chk("irq_low", {31'b0, irq}, 32'h0);
        set_mode(0, 2'b00);
`endif

        for (int k = 0; k < 16; k++) begin
            mode = $urandom_range(0, 3);
            has = 1'($urandom_range(0, 1));
            tx = 8'($urandom);
            mo = 8'($urandom);
            set_mode(mode, 2'b00);
            if (has) bus_write(5'd1, {24'b0, tx});
            exp_miso_q.push_back(has ? tx : 8'hFF);
            exp_rx_q.push_back(mo);
            ss_low();
            xfer(mo, 8, 1);
            ss_high();
            chk("rand_rx", {24'b0, rd_data[7:0]}, {24'b0, mo});
            read_clr();
        end

        repeat (4) @(negedge clk);
        chk("rx_queue_drained", exp_rx_q.size(), 32'h0);
        chk("miso_queue_drained", exp_miso_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI peripheral-side (slave) core on the MMIO slot bus: the responder end of the SPI link, for when an external master drives the clock. It oversamples the external SCLK/MOSI/SS_N in the system clock domain and shifts bytes MSB-first in all four CPOL/CPHA modes. It presents received bytes and accepts transmit bytes through slot registers, with overrun detection.

## Interface
- SYNC_STAGES, 2, synchronizer depth for spi_sclk, spi_mosi and spi_ss_n; minimum 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  slot select.
- read  in  1  slot read strobe.
- write  in  1  slot write strobe.
- addr  in  5  register address; only addr[1:0] is decoded.
- wr_data  in  32  write data.
- rd_data  out  32  status word, combinational from registers.
- spi_sclk  in  1  external SPI clock, asynchronous to clk.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data; 0 while deselected.
- spi_ss_n  in  1  slave select, active-low.
- irq  out  1  level interrupt; exists only with SPI_SLV_IRQ_EN.

## Operation
- Write decode uses wr_en = cs & write.
  - addr[1:0] 01: tx_hold <= wr_data[7:0]; tx_empty <= 0.
  - addr[1:0] 11: cpol <= wr_data[0], cpha <= wr_data[1], ie_rx <= wr_data[2], ie_tx <= wr_data[3].
  - addr[1:0] 00 and 10: ignored.
- Read strobe cs & read & addr[1:0]==00 clears rx_valid and ovr in the next clock.
- rd_data = {16'b0, ie_tx, ie_rx, cpha, cpol, busy, ovr, tx_empty, rx_valid, rx_data[7:0]}. Bit 8 is rx_valid, bit 11 is busy.
- All three SPI inputs pass through SYNC_STAGES flops. One further flop on the synchronized sclk gives edge detect.
- Let m = sclk_s ^ cpol ^ cpha.
  - A rising edge of m is a sample edge.
  - A falling edge of m is a shift edge.
- FSM IDLE:
  - Stays here while ss_n_s = 1.
  - On ss_n_s 1->0: load tx_sh with tx_hold if tx_empty=0, else 0xFF. Set tx_empty <= 1, bit_cnt <= 0, busy <= 1. Go to ACTIVE.
- FSM ACTIVE:
  - On a sample edge: rx_sh <= {rx_sh[6:0], mosi_s}; bit_cnt <= bit_cnt+1.
  - On a shift edge with bit_cnt != 0: tx_sh <= {tx_sh[6:0], 1'b0}.
  - On a shift edge with bit_cnt = 0: no shift. This is what gives correct CPHA=1 behaviour.
- Byte completion (8th sample edge):
  - rx_data <= assembled byte; rx_valid <= 1; bit_cnt <= 0.
  - tx_sh reloads from tx_hold, or 0xFF if tx_hold is empty; tx_empty <= 1.
  - Back-to-back bytes within one SS assertion are supported.
- Overrun: if rx_valid is already 1 at completion and is not being cleared that cycle, then ovr <= 1. rx_data is overwritten with the newest byte.
- spi_miso = busy ? tx_sh[7] : 0.
- ss_n_s 0->1 in ACTIVE:
  - Go to IDLE, busy <= 0, bit_cnt <= 0.
  - A partial byte is discarded. rx_valid, rx_data and ovr are unchanged.
- Simultaneous events:
  - Byte completion beats a same-cycle read-clear: rx_valid stays 1 and ovr is not set.
  - A CPU tx write in the same cycle as a tx_sh load: the load takes the old tx_hold. The new value is stored and tx_empty ends at 0.
- Reset values:
  - rd_data fields all 0 except tx_empty = 1.
  - tx_hold = 0x00, tx_sh = 0xFF, rx_sh = 0, bit_cnt = 0.
  - State IDLE, spi_miso = 0, irq = 0.
- Reset asserted mid-byte aborts the transfer immediately.

## Timing
- A pin edge is detected SYNC_STAGES+1 clk later, i.e. 3 clk at the default.
- spi_miso changes 1 clk after a detected shift edge: 4 clk after the pin edge at default.
- rx_valid and rx_data update 1 clk after the detected 8th sample edge.
- Supported f_sclk <= f_clk/8. SCLK high and low phases must each be >= 4 clk.
- SS_N falling to the first SCLK edge must be >= 4 clk.

## Configuration
- SPI_SLV_IRQ_EN defined:
  - irq port present.
  - irq = (rx_valid & ie_rx) | (tx_empty & ie_tx & busy) | ovr, registered, 1 clk latency.
- SPI_SLV_IRQ_EN undefined:
  - No irq port.
  - ie_rx and ie_tx are not stored and read as 0.

## Test plan
- Mode 0, clk/8: write tx 0xA5; master sends 0x3C -> master receives 0xA5; rd_data[8:0] = 0x13C; tx_empty = 1.
- Modes 1, 2, 3: each with tx 0x81 and mosi 0x7E -> master gets 0x81; rx_data = 0x7E in every mode.
- Two bytes in one SS, with tx rewritten between them (0x11, then 0x22); the CPU does not read -> master gets 0x11, 0x22; rx_data = second byte; ovr = 1. A read at addr 0 then clears bits 8 and 10.
- SS_N raised after 5 bits -> rx_valid stays 0; the next full byte is received correctly; spi_miso = 0 while deselected.
- Empty tx_hold -> master receives 0xFF.
- Reset mid-byte -> all reset values are restored. Read-clear coincident with completion -> rx_valid = 1, ovr = 0.
- With SPI_SLV_IRQ_EN: ie_rx = 1 -> irq rises 1 clk after rx_valid and falls after the read-clear.
